bpf_alu: RTL

BPF_ALU -- requirements
Module: bpf_alu

---
 rtl/bpf_alu_if.sv | 43 ++++
 rtl/bpf_alu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bpf_alu_if.sv
// bpf_alu_if -- operand/result bundle for the bpf_alu block.
//
// Handshake: the requester raises ALU_en for one or more cycles. A rising
// clock edge with ALU_en=1 and ALU_busy=0 starts an operation. Edges with
// ALU_busy=1 ignore ALU_en. Completion is signalled by ALU_vld, which is high
// for exactly one cycle while ALU_out carries the new result. ALU_out then
// holds that value until the next completion. There is no back-pressure on
// the result side.
//
// Signals:
//   A, X, imm    operands (accumulator, auxiliary register, immediate)
//   B_sel        B operand select: 0 = X, 1 = imm
//   ALU_sel      opcode
//   ALU_en       start request
//   ALU_out      result register
//   ALU_vld      one-cycle completion pulse
//   ALU_busy     multi-cycle operation in progress
//   ALU_flags    combinational compare flags of A against B
//   dbg_state    FSM state, exposed for observation (1 = divider running)
// Modports: master = requester side, slave = bpf_alu side.
interface bpf_alu_if;
  logic [31:0] A;
  logic [31:0] X;
  logic [31:0] imm;
  logic        B_sel;
  logic [3:0]  ALU_sel;
  logic        ALU_en;
  logic [31:0] ALU_out;
  logic        ALU_vld;
  logic        ALU_busy;
  logic [3:0]  ALU_flags;
  logic        dbg_state;

  modport master (
    output A, X, imm, B_sel, ALU_sel, ALU_en,
    input  ALU_out, ALU_vld, ALU_busy, ALU_flags, dbg_state
  );

  modport slave (
    input  A, X, imm, B_sel, ALU_sel, ALU_en,
    output ALU_out, ALU_vld, ALU_busy, ALU_flags, dbg_state
  );
endinterface

// File: rtl/bpf_alu.sv
// bpf_alu -- BPF-style 32-bit ALU with an optional iterative divider.
//
// Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 OR, 5 AND, 6 LSH, 7 RSH, 8 NEG,
// 9 MOD, 10 XOR. Opcodes 11-15 return 0. All arithmetic is unsigned, mod 2^32.
// Single-cycle ops complete on the edge that samples ALU_en.
//
// Build option: define BPF_ALU_DIV_EN to build a restoring divider. With it,
// DIV/MOD by a non-zero B take 33 cycles (ALU_busy high for 32 of them). When
// it is undefined, DIV/MOD return 0 in one cycle and ALU_busy is tied low.
// In both builds, division by zero returns 0 in one cycle.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   bpf_alu_if.slave (operands, opcode, start, result, status, flags)
module bpf_alu (
  input  logic     clk,
  input  logic     rst,
  bpf_alu_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_LSH = 4'd6;
  localparam logic [3:0] OP_RSH = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd10;

  logic [31:0] b;
  logic [31:0] quick_res;
  logic [31:0] out_q, out_n;
  logic        vld_q, vld_n;

  assign b = bus.B_sel ? bus.imm : bus.X;

  assign bus.ALU_flags = {|(bus.A & b), bus.A >= b, bus.A > b, bus.A == b};
  assign bus.ALU_out   = out_q;
  assign bus.ALU_vld   = vld_q;

  // Result of every single-cycle opcode. DIV/MOD fall to the default, which
  // covers division by zero and the build without a divider.
  always_comb begin
    quick_res = '0;
    case (bus.ALU_sel)
      OP_ADD:  quick_res = bus.A + b;
      OP_SUB:  quick_res = bus.A - b;
      OP_MUL:  quick_res = bus.A * b;
      OP_OR:   quick_res = bus.A | b;
      OP_AND:  quick_res = bus.A & b;
      // Shift amounts of 32 or more flush the operand completely.
      OP_LSH:  quick_res = (|b[31:5]) ? '0 : (bus.A << b[4:0]);
      OP_RSH:  quick_res = (|b[31:5]) ? '0 : (bus.A >> b[4:0]);
      OP_NEG:  quick_res = (~bus.A) + 32'd1;
      OP_XOR:  quick_res = bus.A ^ b;
      default: quick_res = '0;
    endcase
  end

`ifdef BPF_ALU_DIV_EN

  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd9;

  typedef enum logic [0:0] {IDLE, DIV_RUN} state_t;

  state_t      state_q, state_n;
  logic [4:0]  cnt_q, cnt_n;
  logic [31:0] rem_q, rem_n;   // partial remainder
  logic [31:0] quo_q, quo_n;   // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q, dvs_n;   // captured divisor
  logic        mod_q, mod_n;   // 1 = return remainder
  logic [32:0] shifted;
  logic        qbit;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic        div_op;

  assign div_op = (bus.ALU_sel == OP_DIV) || (bus.ALU_sel == OP_MOD);

  // One restoring step: bring the next dividend bit into the remainder and
  // subtract the divisor when it fits. The difference is below the divisor,
  // so its low 32 bits are exact.
  assign shifted  = {rem_q, quo_q[31]};
  assign qbit     = (shifted >= {1'b0, dvs_q});
  assign step_rem = qbit ? (shifted[31:0] - dvs_q) : shifted[31:0];
  assign step_quo = {quo_q[30:0], qbit};

  assign bus.ALU_busy  = (state_q == DIV_RUN);
  assign bus.dbg_state = (state_q == DIV_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      mod_q   <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      rem_q   <= rem_n;
      quo_q   <= quo_n;
      dvs_q   <= dvs_n;
      mod_q   <= mod_n;
      out_q   <= out_n;
      vld_q   <= vld_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rem_n   = rem_q;
    quo_n   = quo_q;
    dvs_n   = dvs_q;
    mod_n   = mod_q;
    out_n   = out_q;
    vld_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ALU_en) begin
          if (div_op && (b != 32'd0)) begin
            state_n = DIV_RUN;
            cnt_n   = 5'd31;
            rem_n   = '0;
            quo_n   = bus.A;
            dvs_n   = b;
            mod_n   = (bus.ALU_sel == OP_MOD);
          end else begin
            out_n = quick_res;
            vld_n = 1'b1;
          end
        end
      end
      DIV_RUN: begin
        // ALU_en is deliberately not looked at here.
        rem_n = step_rem;
        quo_n = step_quo;
        cnt_n = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_n = IDLE;
          cnt_n   = '0;
          out_n   = mod_q ? step_rem : step_quo;
          vld_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`else

  assign bus.ALU_busy  = 1'b0;
  assign bus.dbg_state = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_n;
      vld_q <= vld_n;
    end
  end

  always_comb begin
    out_n = out_q;
    vld_n = 1'b0;
    if (bus.ALU_en) begin
      out_n = quick_res;
      vld_n = 1'b1;
    end
  end

`endif

endmodule
